// File: rtl/display_scan_ctrl.sv
`default_nettype none
// ============================================================================
// display_scan_ctrl : four-digit seven-segment scan, decode, colon and setup blink
// Optional: DISPLAY_BLINK_EN builds the blink counter and cursor blanking.
// Rev 1.0
// ============================================================================
module display_scan_ctrl #(
    parameter int unsigned SCAN_DIV  = 49999,
    parameter int unsigned BLINK_DIV = 24999999
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       setupMode,
    input  logic [1:0] loc,
    input  logic [3:0] hourUpper,
    input  logic [3:0] hourLower,
    input  logic [3:0] minuteUpper,
    input  logic [3:0] minuteLower,
    input  logic [5:0] secondCounter,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int SCAN_W = (SCAN_DIV > 0) ? $clog2(SCAN_DIV + 1) : 1;

    logic [SCAN_W-1:0] cnt_q, cnt_d;
    logic [1:0]        idx_q, idx_d;
    logic [3:0]        an_q, an_d;
    logic [6:0]        seg_q, seg_d;
    logic              dp_q, dp_d;

    logic              w_tc;
    logic [1:0]        w_idx_nxt;
    logic [3:0]        w_digit;
    logic              w_blank;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'b1000000;
            4'd1:    seg_decode = 7'b1111001;
            4'd2:    seg_decode = 7'b0100100;
            4'd3:    seg_decode = 7'b0110000;
            4'd4:    seg_decode = 7'b0011001;
            4'd5:    seg_decode = 7'b0010010;
            4'd6:    seg_decode = 7'b0000010;
            4'd7:    seg_decode = 7'b1111000;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0010000;
            default: seg_decode = 7'b1111111;
        endcase
    endfunction

    assign w_tc      = (cnt_q == SCAN_W'(SCAN_DIV));
    assign w_idx_nxt = idx_q + 2'd1;

    always_comb begin
        w_digit = hourUpper;
        case (w_idx_nxt)
            2'd0:    w_digit = hourUpper;
            2'd1:    w_digit = hourLower;
            2'd2:    w_digit = minuteUpper;
            default: w_digit = minuteLower;
        endcase
    end

    // Everything visible is captured only at the slot boundary, so a slot is never retimed.
    always_comb begin
        cnt_d = cnt_q + SCAN_W'(1);
        idx_d = idx_q;
        an_d  = an_q;
        seg_d = seg_q;
        dp_d  = dp_q;
        if (w_tc) begin
            cnt_d = '0;
            idx_d = w_idx_nxt;
            an_d  = w_blank ? 4'b1111 : ~(4'b1000 >> w_idx_nxt);
            seg_d = seg_decode(w_digit);
            dp_d  = ~((w_idx_nxt == 2'd1) && !setupMode && !secondCounter[0]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            idx_q <= 2'd3;
            an_q  <= 4'b1111;
            seg_q <= 7'b1111111;
            dp_q  <= 1'b1;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
        end
    end

`ifdef DISPLAY_BLINK_EN
    localparam int BLINK_W = (BLINK_DIV > 0) ? $clog2(BLINK_DIV + 1) : 1;

    logic [BLINK_W-1:0] bcnt_q, bcnt_d;
    logic               phase_q, phase_d;
    logic [1:0]         loc_q;
    logic               setup_q;
    logic               w_clr;

    assign w_clr = (loc != loc_q) || (setupMode && !setup_q);

    always_comb begin
        bcnt_d  = bcnt_q + BLINK_W'(1);
        phase_d = phase_q;
        if (w_clr) begin
            bcnt_d  = '0;
            phase_d = 1'b1;
        end else if (bcnt_q == BLINK_W'(BLINK_DIV)) begin
            bcnt_d  = '0;
            phase_d = ~phase_q;
        end
    end

    // Edge-detect history tracks inputs even in reset so a steady cursor causes no spurious clear.
    always_ff @(posedge clk) begin
        loc_q   <= loc;
        setup_q <= setupMode;
        if (rst) begin
            bcnt_q  <= '0;
            phase_q <= 1'b1;
        end else begin
            bcnt_q  <= bcnt_d;
            phase_q <= phase_d;
        end
    end

    assign w_blank = setupMode && !phase_q && (w_idx_nxt == loc);

    logic unused_sig;
    assign unused_sig = ^secondCounter[5:1];
`else
    assign w_blank = 1'b0;

    logic unused_sig;
    assign unused_sig = ^{loc, secondCounter[5:1]} ^ (BLINK_DIV == 0);
`endif

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule
`default_nettype wire
